// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//
// Single-port data memory with a programmable access latency, sitting in
// front of a processor that stalls its whole pipeline while DataDone is low.
//
// A request is taken only when the controller is idle. Writes commit to the
// array on the accept edge. Reads return data either on the accept edge
// (WAIT_CYCLES = 0) or on the edge that leaves the WAIT state. Addresses at
// or above MEM_DEPTH are flagged with a one-cycle AddrErr pulse. Such a write
// is dropped and such a read returns zero; the latency is the same as for a
// normal access.
//
// Parameters
//   WORD_SIZE   : data and address width in bits
//   MEM_DEPTH   : number of words (power of two, <= 2**WORD_SIZE)
//   WAIT_CYCLES : stall cycles added per access (0..15)
//
// Ports
//   Clock     in   sole clock, rising edge
//   Reset     in   synchronous, active-high
//   DataAddr  in   word address of the request
//   DataOut   in   write data from the processor
//   ReadData  in   read request
//   WriteData in   write request (wins over ReadData)
//   DataIn    out  registered read data to the processor
//   DataDone  out  1 = idle / access complete, 0 = processor must stall
//   AddrErr   out  one-cycle pulse after accepting an out-of-range access
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 AddrErr
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // The depth is widened by one bit so that MEM_DEPTH == 2**WORD_SIZE still
    // compares correctly against a full-width address.
    localparam logic [WORD_SIZE:0] DEPTH_EXT = (WORD_SIZE + 1)'(MEM_DEPTH);

    // The counter starts at W-1, so DataDone stays low for exactly W cycles.
    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [AW-1:0]        lat_index;   // address captured at accept
    logic                 lat_read;    // accepted access is a read
    logic                 lat_ok;      // captured address was in range

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic                 in_range;
    logic [AW-1:0]        index;
    logic                 accept;
    logic                 do_write;

    assign in_range = {1'b0, DataAddr} < DEPTH_EXT;
    assign index    = DataAddr[AW-1:0];

    // Reset wins over any request seen in the same cycle. Inputs are
    // ignored in WAIT because the stalled processor keeps driving the next
    // instruction's request.
    assign accept   = (state == S_IDLE) && (ReadData || WriteData) && !Reset;
    assign do_write = accept && WriteData && in_range;

    assign DataDone = (state == S_IDLE);

    // The array has no reset, so its contents survive Reset. Write data is
    // captured directly into the array on the accept edge. Because of this,
    // no separate copy of it is kept, and a request issued in the next cycle
    // already sees the new value.
    always_ff @(posedge Clock) begin
        if (do_write) begin
            mem[index] <= DataOut;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            DataIn    <= '0;
            AddrErr   <= 1'b0;
            lat_index <= '0;
            lat_read  <= 1'b0;
            lat_ok    <= 1'b0;
        end else begin
            AddrErr <= accept && !in_range;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_index <= index;
                        lat_read  <= !WriteData;
                        lat_ok    <= in_range;
                        if (WAIT_CYCLES == 0) begin
                            // No latency: the read completes on the accept edge.
                            if (!WriteData) begin
                                DataIn <= in_range ? mem[index] : '0;
                            end
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_IDLE;
                        // DataIn is valid in the first DataDone=1 cycle.
                        if (lat_read) begin
                            DataIn <= lat_ok ? mem[lat_index] : '0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Directed test of data_memory_ctrl. It uses two instances: one with zero
// wait states and one with two wait states. Inputs change 1 time unit after
// the rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] a0, d0, q0;
    logic        rd0, wr0, done0, err0;
    logic [15:0] a2, d2, q2;
    logic        rd2, wr2, done2, err2;
    logic        e1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.WORD_SIZE(16), .MEM_DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .Clock(clk), .Reset(rst), .DataAddr(a0), .DataOut(d0),
        .ReadData(rd0), .WriteData(wr0),
        .DataIn(q0), .DataDone(done0), .AddrErr(err0)
    );

    data_memory_ctrl #(.WORD_SIZE(16), .MEM_DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .Clock(clk), .Reset(rst), .DataAddr(a2), .DataOut(d2),
        .ReadData(rd2), .WriteData(wr2),
        .DataIn(q2), .DataDone(done2), .AddrErr(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put2(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rd2 = r; wr2 = w; a2 = a; d2 = d;
    endtask

    // Runs one full two-wait-state access on dut2. e is AddrErr, sampled in
    // the cycle after accept.
    task automatic acc2(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output logic e);
        put2(r, w, a, d);
        tick;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        e = err2;
        tick;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a0 = 0; d0 = 0; rd0 = 0; wr0 = 0;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        tick;
        tick;
        rst = 1'b0;

        // Reset state
        chk("rst_q0",    q0,    0);
        chk("rst_done0", done0, 1);
        chk("rst_q2",    q2,    0);
        chk("rst_done2", done2, 1);
        chk("rst_err2",  err2,  0);

        // Zero wait states: write, then read the same address next cycle
        wr0 = 1; a0 = 16'd5; d0 = 16'h1234;
        tick;
        chk("w0_wr_done", done0, 1);
        chk("w0_wr_qhold", q0, 0);
        wr0 = 0; rd0 = 1;
        tick;
        chk("w0_rd_q",    q0,    16'h1234);
        chk("w0_rd_done", done0, 1);
        a0 = 16'd300;
        tick;
        chk("w0_oor_q",   q0,   0);
        chk("w0_oor_err", err0, 1);
        rd0 = 0;
        tick;
        chk("w0_err_pulse", err0, 0);
        chk("w0_q_hold",    q0,   0);

        // Two wait states: preload addresses 5 and 6
        put2(1'b0, 1'b1, 16'd5, 16'hBEEF);
        tick;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        chk("w2_wr_stall", done2, 0);
        tick;
        tick;
        chk("w2_wr_done", done2, 1);
        chk("w2_wr_qhold", q2, 0);
        acc2(1'b0, 1'b1, 16'd6, 16'h5678, e1);

        // Read addr 5, latency of exactly two stall cycles
        put2(1'b1, 1'b0, 16'd5, 16'd0);
        chk("r5_n_done", done2, 1);
        tick;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        chk("r5_n1_done", done2, 0);
        tick;
        chk("r5_n2_done", done2, 0);
        chk("r5_n2_q",    q2,    0);
        tick;
        chk("r5_n3_done", done2, 1);
        chk("r5_n3_q",    q2,    16'hBEEF);

        // Read of addr 6 held during WAIT: ignored until IDLE
        put2(1'b1, 1'b0, 16'd5, 16'd0);
        tick;
        a2 = 16'd6;
        chk("hold_n1_done", done2, 0);
        tick;
        chk("hold_n2_done", done2, 0);
        tick;
        chk("hold_n3_done", done2, 1);
        chk("hold_n3_q",    q2,    16'hBEEF);
        tick;
        rd2 = 1'b0;
        chk("hold_m1_done", done2, 0);
        tick;
        chk("hold_m2_q",    q2,    16'hBEEF);
        tick;
        chk("hold_m3_done", done2, 1);
        chk("hold_m3_q",    q2,    16'h5678);

        // Read and write both asserted: write wins, DataIn held
        acc2(1'b1, 1'b1, 16'd7, 16'h00AA, e1);
        chk("rw_qhold", q2, 16'h5678);
        acc2(1'b1, 1'b0, 16'd7, 16'd0, e1);
        chk("rw_mem7", q2, 16'h00AA);

        // Out-of-range accesses
        acc2(1'b0, 1'b1, 16'd44, 16'h4444, e1);
        put2(1'b1, 1'b0, 16'd300, 16'd0);
        tick;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        chk("oor_rd_err",   err2,  1);
        chk("oor_rd_stall", done2, 0);
        tick;
        chk("oor_rd_pulse", err2,  0);
        tick;
        chk("oor_rd_q",     q2,    0);
        chk("oor_rd_done",  done2, 1);
        acc2(1'b0, 1'b1, 16'd300, 16'hDEAD, e1);
        chk("oor_wr_err", e1, 1);
        acc2(1'b1, 1'b0, 16'd44, 16'd0, e1);
        chk("oor_wr_alias", q2, 16'h4444);
        chk("in_rng_err",   e1, 0);
        acc2(1'b1, 1'b0, 16'd256, 16'd0, e1);
        chk("edge256_err", e1, 1);
        acc2(1'b0, 1'b1, 16'd255, 16'h0FF0, e1);
        acc2(1'b1, 1'b0, 16'd255, 16'd0, e1);
        chk("edge255_q",   q2, 16'h0FF0);
        chk("edge255_err", e1, 0);

        // Reset in the second WAIT cycle aborts the read
        put2(1'b1, 1'b0, 16'd5, 16'd0);
        tick;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_done", done2, 1);
        chk("abort_q",    q2,    0);
        chk("abort_err",  err2,  0);

        // A write presented together with Reset is not accepted
        put2(1'b0, 1'b1, 16'd5, 16'h1111);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        put2(1'b0, 1'b0, 16'd0, 16'd0);
        chk("rstwr_done", done2, 1);
        acc2(1'b1, 1'b0, 16'd5, 16'd0, e1);
        chk("rstwr_mem5", q2, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data and address width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of words, power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, stall cycles added per access.
REQ-004 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port DataAddr, input, WORD_SIZE, word address of the request.
REQ-007 SHALL have port DataOut, input, WORD_SIZE, write data from the processor.
REQ-008 SHALL have port ReadData, input, 1, read request.
REQ-009 SHALL have port WriteData, input, 1, write request.
REQ-010 SHALL have port DataIn, output, WORD_SIZE, registered read data to the processor.
REQ-011 SHALL have port DataDone, output, 1; low means the processor stalls its whole pipeline.
REQ-012 SHALL have port AddrErr, output, 1, one-cycle pulse flagging an out-of-range access.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT; DataDone is combinationally 1 in IDLE and 0 in WAIT.
REQ-014 SHALL accept a request only in a cycle where the state is IDLE and ReadData or WriteData is 1.
REQ-015 SHALL ignore ReadData, WriteData, DataAddr and DataOut while in WAIT, because the stalled processor keeps presenting the next instruction's request.
REQ-016 SHALL latch the accepted address, the read/write kind and the write data at the accept edge.
REQ-017 SHALL perform an accepted write into the memory array at the accept edge; DataIn is unchanged by writes.
REQ-018 SHALL, with WAIT_CYCLES=0, stay in IDLE and load DataIn with mem[DataAddr] at the accept edge, so data is valid in the cycle after the request.
REQ-019 SHALL, with WAIT_CYCLES=W>0, enter WAIT at the accept edge with the counter loaded to W-1.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and return to IDLE on the edge where the counter is 0; DataDone is 0 for exactly W cycles.
REQ-021 SHALL, for an accepted read, load DataIn from the array on the WAIT-to-IDLE edge, so DataIn is valid in the first IDLE cycle with DataDone=1.
REQ-022 SHALL accept a new request in that first IDLE cycle, which allows back-to-back accesses with no idle gap.
REQ-023 SHALL give WriteData priority when ReadData and WriteData are both 1: the access is a write, no read is performed, and DataIn is held.
REQ-024 SHALL treat DataAddr >= MEM_DEPTH as out-of-range: writes are discarded, reads load DataIn with 0, wait timing is unchanged, and AddrErr is 1 in the cycle after accept.
REQ-025 SHALL hold DataIn between completed reads; DataIn changes only on read completion or reset.
REQ-026 SHALL give a request presented in the cycle right after a write to the same address the newly written data.

Reset
REQ-027 SHALL, when Reset=1 at a rising edge, set the state to IDLE, the counter to 0, DataIn to 0 and AddrErr to 0.
REQ-028 SHALL drive DataDone=1 in the cycle after reset.
REQ-029 SHALL have Reset override any request sampled in the same cycle; that request is not accepted and no array write occurs.
REQ-030 SHALL have Reset during WAIT abort the access, leave DataIn at 0, and keep any write already performed at accept.
REQ-031 SHALL NOT clear memory array contents on reset.

Verification
REQ-032 SHALL cover: W=0, write 0x1234 to addr 5, next cycle read addr 5 -> DataDone always 1, DataIn=0x1234 the cycle after the read.
REQ-033 SHALL cover: W=2, read addr 5 holding 0xBEEF -> DataDone 0 for exactly cycles N+1 and N+2, DataIn=0xBEEF with DataDone=1 in cycle N+3.
REQ-034 SHALL cover: W=2, second read of addr 6 held asserted during WAIT -> ignored until IDLE, then accepted, returning mem[6] three cycles later.
REQ-035 SHALL cover: ReadData=WriteData=1, addr 7, data 0x00AA -> mem[7]=0x00AA, DataIn unchanged.
REQ-036 SHALL cover: read addr 300 with MEM_DEPTH=256 -> AddrErr pulse 1 cycle, DataIn=0; write addr 300 -> array unchanged.
REQ-037 SHALL cover: Reset asserted in the second WAIT cycle -> next cycle state IDLE, DataDone=1, DataIn=0; a subsequent read returns the pre-reset stored value.
